// File: rtl/wiper_pkg.sv
// rtl/wiper_pkg.sv - speed command and sweep state types shared with the rain controller
package wiper_pkg;

  typedef enum logic [1:0] {
    SPD_OFF      = 2'd0,
    SPD_SLOW     = 2'd1,
    SPD_FAST     = 2'd2,
    SPD_FAST_ALT = 2'd3
  } speed_e;

  typedef enum logic [1:0] {
    ST_PARKED = 2'd0,
    ST_UP     = 2'd1,
    ST_DOWN   = 2'd2,
    ST_RETURN = 2'd3
  } sweep_state_e;

  localparam logic [2:0] ARM_MAX      = 3'd7;
  localparam int         DEF_SLOW_DIV = 4;
  localparam int         DEF_FAST_DIV = 2;
  localparam int         DIV_W        = 8;

  function automatic logic [7:0] arm_one_hot(input logic [2:0] pos);
    return 8'b0000_0001 << pos;
  endfunction

endpackage

// File: rtl/wiper_prescaler.sv
// rtl/wiper_prescaler.sv - step tick generator, one tick every div cycles
module wiper_prescaler
  import wiper_pkg::*;
(
  input  logic             clk_2,
  input  logic             reset,
  input  logic [DIV_W-1:0] div,
  input  logic             clear,
  output logic             tick
);

  localparam logic [DIV_W-1:0] ONE = {{(DIV_W-1){1'b0}}, 1'b1};

  logic [DIV_W-1:0] cnt;

  assign tick = (cnt == (div - ONE));

  always_ff @(posedge clk_2) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + ONE;
    end
  end

endmodule

// File: rtl/wiper_sweep.sv
// rtl/wiper_sweep.sv - wiper arm sweep sequencer driven by the rain controller speed
module wiper_sweep
  import wiper_pkg::*;
#(
  parameter int SLOW_DIV = DEF_SLOW_DIV,
  parameter int FAST_DIV = DEF_FAST_DIV
) (
  input  logic       clk_2,
  input  logic       reset,
  input  logic [1:0] speed,
  output logic [2:0] arm_pos,
  output logic [7:0] arm_bar,
  output logic       dir,
  output logic       moving,
  output logic [7:0] sweep_cnt
);

  localparam logic [DIV_W-1:0] SLOW_D = DIV_W'(SLOW_DIV);
  localparam logic [DIV_W-1:0] FAST_D = DIV_W'(FAST_DIV);

  speed_e           speed_q;
  sweep_state_e     state;
  sweep_state_e     state_nxt;
  logic [2:0]       arm_nxt;
  logic             cnt_inc;
  logic             clear_entry;
  logic             run;
  logic             tick;
  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_nxt;
  logic             clear;

  function automatic logic [DIV_W-1:0] div_for(input sweep_state_e s, input logic fast);
    return ((s == ST_UP || s == ST_DOWN) && fast) ? FAST_D : SLOW_D;
  endfunction

  assign run = (speed_q != SPD_OFF);

  // Clearing on the edge where div is about to change means the new rate
  // starts counting from 0 in the very first cycle it is in force.
  assign div     = div_for(state, speed_q[1]);
  assign div_nxt = reset ? SLOW_D : div_for(state_nxt, speed[1]);
  assign clear   = clear_entry || (div_nxt != div);

  wiper_prescaler u_prescaler (
    .clk_2 (clk_2),
    .reset (reset),
    .div   (div),
    .clear (clear),
    .tick  (tick)
  );

  always_comb begin
    state_nxt   = state;
    arm_nxt     = arm_pos;
    cnt_inc     = 1'b0;
    clear_entry = 1'b0;
    case (state)
      ST_PARKED: begin
        arm_nxt = 3'd0;
        if (run) begin
          state_nxt   = ST_UP;
          clear_entry = 1'b1;
        end
      end
      ST_UP: begin
        // An off command wins over a tick landing in the same cycle.
        if (!run) begin
          state_nxt   = ST_RETURN;
          clear_entry = 1'b1;
        end else if (tick) begin
          arm_nxt = arm_pos + 3'd1;
          if (arm_pos == ARM_MAX - 3'd1) state_nxt = ST_DOWN;
        end
      end
      ST_DOWN: begin
        if (!run) begin
          state_nxt   = ST_RETURN;
          clear_entry = 1'b1;
        end else if (tick) begin
          arm_nxt = arm_pos - 3'd1;
          if (arm_pos == 3'd1) begin
            cnt_inc   = 1'b1;
            state_nxt = ST_UP;
          end
        end
      end
      ST_RETURN: begin
        if (arm_pos == 3'd0) begin
          state_nxt = ST_PARKED;
        end else if (run) begin
          state_nxt = ST_DOWN;
        end else if (tick) begin
          arm_nxt = arm_pos - 3'd1;
          if (arm_pos == 3'd1) state_nxt = ST_PARKED;
        end
      end
      default: begin
        state_nxt = ST_PARKED;
      end
    endcase
  end

  always_ff @(posedge clk_2) begin
    if (reset) begin
      speed_q   <= SPD_OFF;
      state     <= ST_PARKED;
      arm_pos   <= 3'd0;
      dir       <= 1'b0;
      moving    <= 1'b0;
      sweep_cnt <= 8'd0;
    end else begin
      speed_q <= speed_e'(speed);
      state   <= state_nxt;
      arm_pos <= arm_nxt;
      dir     <= (state_nxt == ST_UP);
      moving  <= (state_nxt != ST_PARKED);
      if (cnt_inc) sweep_cnt <= sweep_cnt + 8'd1;
    end
  end

  assign arm_bar = arm_one_hot(arm_pos);

endmodule

// File: tb/tb_wiper_sweep.sv
// tb/tb_wiper_sweep.sv - directed checks of wiper_sweep sweep, return, resume and wrap behaviour
module tb_wiper_sweep;

  logic       clk_2 = 1'b0;
  logic       reset;
  logic [1:0] speed;
  logic [2:0] arm_pos;
  logic [7:0] arm_bar;
  logic       dir;
  logic       moving;
  logic [7:0] sweep_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  wiper_sweep #(.SLOW_DIV(4), .FAST_DIV(2)) dut (
    .clk_2     (clk_2),
    .reset     (reset),
    .speed     (speed),
    .arm_pos   (arm_pos),
    .arm_bar   (arm_bar),
    .dir       (dir),
    .moving    (moving),
    .sweep_cnt (sweep_cnt)
  );

  always #5 clk_2 = ~clk_2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_2);
    #1;
  endtask

  task automatic check_rst(input string tag);
    check({tag, "_pos"},    arm_pos,   0);
    check({tag, "_bar"},    arm_bar,   8'h01);
    check({tag, "_dir"},    dir,       0);
    check({tag, "_moving"}, moving,    0);
    check({tag, "_cnt"},    sweep_cnt, 0);
  endtask

  // Reset held for two edges, then released together with the new speed.
  task automatic restart(input logic [1:0] spd);
    reset = 1'b1;
    speed = 2'd0;
    step(2);
    reset = 1'b0;
    speed = spd;
  endtask

  initial begin
    reset = 1'b1;
    speed = 2'd0;

    // Slow sweep from park
    restart(2'd1);
    check_rst("rst");
    step(1);
    check("slow_still_parked", moving, 0);
    step(1);
    check("slow_moving",   moving,  1);
    check("slow_dir_up",   dir,     1);
    check("slow_pos0",     arm_pos, 0);
    step(3);
    check("slow_pos0_late", arm_pos, 0);
    step(1);
    check("slow_pos1",     arm_pos, 1);
    check("slow_bar1",     arm_bar, 8'h02);
    step(23);
    check("slow_pos6",     arm_pos, 6);
    check("slow_pos6_dir", dir,     1);
    step(1);
    check("slow_pos7",     arm_pos, 7);
    check("slow_bar7",     arm_bar, 8'h80);
    check("slow_down_dir", dir,     0);
    step(28);
    check("slow_back0",    arm_pos,   0);
    check("slow_cnt1",     sweep_cnt, 1);
    check("slow_reup",     dir,       1);

    // Fast sweeps, back to back
    restart(2'd2);
    step(2);
    check("fast_moving", moving, 1);
    step(1);
    check("fast_pos0",   arm_pos, 0);
    step(1);
    check("fast_pos1",   arm_pos, 1);
    step(12);
    check("fast_pos7",   arm_pos, 7);
    check("fast_dir7",   dir,     0);
    step(14);
    check("fast_cnt1",   sweep_cnt, 1);
    check("fast_pos0b",  arm_pos,   0);
    check("fast_noidle", dir,       1);
    step(56);
    check("fast_cnt3",   sweep_cnt, 3);
    check("fast_pos0c",  arm_pos,   0);
    check("fast_dir3",   dir,       1);
    check("fast_mov3",   moving,    1);

    // Off at pos 5 while sweeping up: return to park
    restart(2'd1);
    step(22);
    check("ret_pos5",     arm_pos, 5);
    check("ret_pos5_dir", dir,     1);
    speed = 2'd0;
    step(2);
    check("ret_dir",      dir,     0);
    check("ret_moving",   moving,  1);
    check("ret_hold5",    arm_pos, 5);
    step(3);
    check("ret_still5",   arm_pos, 5);
    step(1);
    check("ret_pos4",     arm_pos, 4);
    step(4);
    check("ret_pos3",     arm_pos, 3);
    step(11);
    check("ret_pos1",     arm_pos, 1);
    check("ret_mov1",     moving,  1);
    step(1);
    check("ret_pos0",     arm_pos,   0);
    check("ret_parked",   moving,    0);
    check("ret_cnt",      sweep_cnt, 0);
    step(3);
    check("ret_stay",     moving,    0);

    // Resume fast from return at pos 3
    restart(2'd1);
    step(22);
    speed = 2'd0;
    step(10);
    check("res_pos3",   arm_pos, 3);
    check("res_in_ret", dir,     0);
    speed = 2'd2;
    step(2);
    check("res_hold3",  arm_pos, 3);
    check("res_moving", moving,  1);
    step(2);
    check("res_pos2",   arm_pos, 2);
    step(2);
    check("res_pos1",   arm_pos, 1);
    step(2);
    check("res_pos0",   arm_pos,   0);
    check("res_cnt",    sweep_cnt, 1);
    check("res_up",     dir,       1);
    step(2);
    check("res_pos1up", arm_pos, 1);

    // Sweep counter wrap
    restart(2'd2);
    step(2);
    step(255 * 28);
    check("wrap_cnt255", sweep_cnt, 255);
    check("wrap_pos0",   arm_pos,   0);
    step(28);
    check("wrap_cnt0",   sweep_cnt, 0);
    check("wrap_dir",    dir,       1);

    // Reset mid-sweep while moving down
    restart(2'd1);
    step(34);
    check("mid_pos6", arm_pos, 6);
    check("mid_dir",  dir,     0);
    reset = 1'b1;
    step(1);
    check_rst("mid_rst");
    reset = 1'b0;
    step(1);
    check("mid_rel1", moving, 0);
    step(1);
    check("mid_rel2_mov", moving,  1);
    check("mid_rel2_pos", arm_pos, 0);
    step(4);
    check("mid_pos1", arm_pos, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
